// File: rtl/fetch_queue_unit.sv
// ----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction-fetch front end: PC sequencer, in-order imem request/response
// interface and a DEPTH-entry instruction queue feeding the IF/ID register.
//
// Handshake rule used on every channel of this block: a transfer happens on
// the rising edge where valid && ready are both high. A valid, once raised,
// does not depend on ready. The only exception is imem_req_valid, which drops
// combinationally in a redirect cycle.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   imem_req_valid/addr  fetch request (word-aligned address)
//   imem_req_ready       memory accepts the request this cycle
//   imem_rsp_valid/data  in-order instruction response
//   redirect_valid/pc    taken branch/jump from MA; flushes the front end
//   instr_valid/instr    queue head (NOP when empty)
//   instr_pc             PC of queue head (0 when empty)
//   decode_ready         ID accepts the head
//   queue_count          queue occupancy, for monitoring
// ----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int          XLEN            = 32,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  output logic [XLEN-1:0]              imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_rsp_valid,
  input  logic [XLEN-1:0]              imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         instr_valid,
  output logic [XLEN-1:0]              instr,
  output logic [XLEN-1:0]              instr_pc,
  input  logic                         decode_ready,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // Sequencer and bookkeeping state
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop_cnt;

  // Queue storage (no reset needed: guarded by r_count)
  logic [XLEN-1:0] r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];

  logic            w_req_fire;
  logic            w_enq;
  logic            w_deq;
  logic [OW-1:0]   w_live;
  logic [SW-1:0]   w_credit;
  logic [XLEN-1:0] w_redirect_aligned;

  // Requests that will still produce a queue entry: responses being dropped
  // do not consume queue space, so they are excluded from the credit.
  assign w_live   = r_outstanding - r_drop_cnt;
  assign w_credit = SW'(r_count) + SW'(w_live);

  assign imem_req_valid = !redirect_valid
                          && (w_credit < SW'(DEPTH))
                          && (r_outstanding < OW'(MAX_OUTSTANDING));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

  // A response is kept only when nothing is pending to be dropped and no
  // redirect is flushing the queue in the same cycle.
  assign w_enq = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

  assign instr_valid = (r_count != '0);
  assign w_deq       = instr_valid && decode_ready;
  assign instr       = instr_valid ? r_q_instr[r_rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? r_q_pc[r_rd_ptr]    : '0;
  assign queue_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= XLEN'(RESET_PC);
      r_rsp_pc      <= XLEN'(RESET_PC);
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // No request is issued this cycle, so only a response can change
      // the outstanding count. Everything still in flight afterwards is stale.
      r_fetch_pc    <= w_redirect_aligned;
      r_rsp_pc      <= w_redirect_aligned;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - OW'(imem_rsp_valid);
      r_drop_cnt    <= r_outstanding - OW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(imem_rsp_valid);
      if (imem_rsp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - OW'(1);
      end
      if (w_enq) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

endmodule
